// File: rtl/ol_pkg.sv
// Shared types and defaults for the output-layer MAC sequencer.
// Holds the FSM state encoding, the fp32 zero pattern and address-width helper.
package ol_pkg;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam int          N_IN_DEF    = 64;
    localparam int          N_OUT_DEF   = 10;
    localparam int          MAC_LAT_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FETCH,
        LOAD,
        HOLD,
        EMIT,
        DONE
    } state_t;

    // Width of an index over n entries; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ol_mac_seq_fp32_gt.sv
// Combinational a > b on fp32 bit patterns using sign-magnitude ordering.
// +0 and -0 compare equal; NaN patterns are not treated specially.
module fp32_gt (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        gt_o
);

    logic [30:0] mag_a;
    logic [30:0] mag_b;

    assign mag_a = a_i[30:0];
    assign mag_b = b_i[30:0];

    always_comb begin
        gt_o = 1'b0;
        if (mag_a == '0 && mag_b == '0) begin
            gt_o = 1'b0;
        end else if (!a_i[31] && b_i[31]) begin
            gt_o = 1'b1;
        end else if (a_i[31] && !b_i[31]) begin
            gt_o = 1'b0;
        end else if (!a_i[31]) begin
            gt_o = (mag_a > mag_b);
        end else begin
            // Both negative: smaller magnitude is the larger value.
            gt_o = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/ol_mac_seq.sv
// Output-layer sequencer: feeds activation/weight pairs to an external fp32 MAC,
// holds them MAC_LAT cycles, accumulates via psum and emits one score per neuron.
// Optional argmax outputs are enabled by defining OL_ARGMAX_EN.
module ol_mac_seq
    import ol_pkg::*;
#(
    parameter int  N_IN    = N_IN_DEF,
    parameter int  N_OUT   = N_OUT_DEF,
    parameter int  MAC_LAT = MAC_LAT_DEF,
    localparam int IN_AW   = addr_w(N_IN),
    localparam int W_AW    = addr_w(N_IN * N_OUT),
    localparam int OUT_AW  = addr_w(N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [31:0]       in_data,
    output logic [W_AW-1:0]   w_addr,
    input  logic [31:0]       w_data,
    output logic [31:0]       mac_ifmap,
    output logic [31:0]       mac_weight,
    output logic [31:0]       mac_psum,
    input  logic [31:0]       mac_ofmap,
    output logic              res_valid,
    output logic [OUT_AW-1:0] res_idx,
`ifdef OL_ARGMAX_EN
    output logic              pred_valid,
    output logic [OUT_AW-1:0] pred_class,
`endif
    output logic [31:0]       res_data
);

    localparam int              HC_W      = addr_w(MAC_LAT);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAC_LAT - 1);

    state_t              state_q,   state_d;
    logic [IN_AW-1:0]    in_addr_q, in_addr_d;
    logic [W_AW-1:0]     w_addr_q,  w_addr_d;
    logic [31:0]         ifmap_q,   ifmap_d;
    logic [31:0]         weight_q,  weight_d;
    logic [31:0]         psum_q,    psum_d;
    logic [HC_W-1:0]     hold_q,    hold_d;
    logic [OUT_AW-1:0]   neuron_q,  neuron_d;
    logic [OUT_AW-1:0]   res_idx_q, res_idx_d;
    logic [31:0]         res_data_q, res_data_d;

    always_comb begin
        state_d    = state_q;
        in_addr_d  = in_addr_q;
        w_addr_d   = w_addr_q;
        ifmap_d    = ifmap_q;
        weight_d   = weight_q;
        psum_d     = psum_q;
        hold_d     = hold_q;
        neuron_d   = neuron_q;
        res_idx_d  = res_idx_q;
        res_data_d = res_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    neuron_d = '0;
                    state_d  = CLR;
                end
            end
            CLR: begin
                psum_d    = FP_ZERO;
                in_addr_d = '0;
                w_addr_d  = W_AW'(int'(neuron_q) * N_IN);
                state_d   = FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                ifmap_d  = in_data;
                weight_d = w_data;
                hold_d   = '0;
                state_d  = HOLD;
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    psum_d = mac_ofmap;
                    if (in_addr_q == IN_AW'(N_IN - 1)) begin
                        res_data_d = mac_ofmap;
                        res_idx_d  = neuron_q;
                        state_d    = EMIT;
                    end else begin
                        in_addr_d = in_addr_q + 1'b1;
                        w_addr_d  = w_addr_q + 1'b1;
                        state_d   = FETCH;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            EMIT: begin
                if (neuron_q == OUT_AW'(N_OUT - 1)) begin
                    state_d = DONE;
                end else begin
                    neuron_d = neuron_q + 1'b1;
                    state_d  = CLR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            ifmap_q    <= '0;
            weight_q   <= '0;
            psum_q     <= FP_ZERO;
            hold_q     <= '0;
            neuron_q   <= '0;
            res_idx_q  <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            in_addr_q  <= in_addr_d;
            w_addr_q   <= w_addr_d;
            ifmap_q    <= ifmap_d;
            weight_q   <= weight_d;
            psum_q     <= psum_d;
            hold_q     <= hold_d;
            neuron_q   <= neuron_d;
            res_idx_q  <= res_idx_d;
            res_data_q <= res_data_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign res_valid  = (state_q == EMIT);
    assign in_addr    = in_addr_q;
    assign w_addr     = w_addr_q;
    assign mac_ifmap  = ifmap_q;
    assign mac_weight = weight_q;
    assign mac_psum   = psum_q;
    assign res_idx    = res_idx_q;
    assign res_data   = res_data_q;

`ifdef OL_ARGMAX_EN
    logic [31:0]       max_val_q;
    logic [OUT_AW-1:0] max_idx_q;
    logic [OUT_AW-1:0] pred_class_q;
    logic              pred_valid_q;
    logic              cand_gt;
    logic              cand_wins;

    fp32_gt u_gt (
        .a_i  (res_data_q),
        .b_i  (max_val_q),
        .gt_o (cand_gt)
    );

    // First score of a pass always seeds the max; strict compare keeps lower index on ties.
    assign cand_wins = (neuron_q == '0) || cand_gt;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_val_q    <= '0;
            max_idx_q    <= '0;
            pred_class_q <= '0;
            pred_valid_q <= 1'b0;
        end else begin
            pred_valid_q <= (state_d == DONE);
            if (state_q == EMIT) begin
                if (cand_wins) begin
                    max_val_q <= res_data_q;
                    max_idx_q <= neuron_q;
                end
                if (state_d == DONE) begin
                    pred_class_q <= cand_wins ? neuron_q : max_idx_q;
                end
            end
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_class = pred_class_q;
`endif

endmodule
